// File: rtl/axis_log_packer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_log_packer
//  Purpose  : Register-slice consumer for the governor's log AXI Stream port.
//             Every logged flit becomes a two-flit record on a plain AXI
//             Stream: a header flit that carries the input side channels
//             (and optionally a capture timestamp) in TDATA, followed by a
//             data flit that carries the original TDATA with TLAST set.
//  Ports    : clk, rstn (async, active-low)
//             log_T*  - input stream (TDATA/TVALID/TREADY/TKEEP/TDEST/TID/TLAST)
//                       log_TREADY is a pure register output
//             pk_T*   - output stream (TDATA/TVALID/TREADY/TKEEP/TLAST)
//  Header   : LSB first {keep, dest, id, last, ts}; ts fills the upper
//             TS_W = DATA_WIDTH - HDR_W bits.
//  Options  : `define LOG_PACK_TIMESTAMP_EN to enable the free-running capture
//             timestamp; when undefined the ts field of the header is zero.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_log_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    // log stream in
    input  logic [DATA_WIDTH-1:0]    log_TDATA,
    input  logic                     log_TVALID,
    output logic                     log_TREADY,
    input  logic [DATA_WIDTH/8-1:0]  log_TKEEP,
    input  logic [DEST_WIDTH-1:0]    log_TDEST,
    input  logic [ID_WIDTH-1:0]      log_TID,
    input  logic                     log_TLAST,
    // packed stream out
    output logic [DATA_WIDTH-1:0]    pk_TDATA,
    output logic                     pk_TVALID,
    input  logic                     pk_TREADY,
    output logic [DATA_WIDTH/8-1:0]  pk_TKEEP,
    output logic                     pk_TLAST
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int HDR_W  = KEEP_W + DEST_WIDTH + ID_WIDTH + 1;
    localparam int TS_W   = DATA_WIDTH - HDR_W;

    generate
        if (TS_W < 1) begin : g_bad_width
            $error("axis_log_packer: DATA_WIDTH too small to hold the header side channels");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // 2-entry capture FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem_data [2];
    logic [KEEP_W-1:0]     r_mem_keep [2];
    logic [DEST_WIDTH-1:0] r_mem_dest [2];
    logic [ID_WIDTH-1:0]   r_mem_id   [2];
    logic                  r_mem_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_ready;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pk_data;
    logic                  r_pk_valid;
    logic                  r_pk_last;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_next_count;
    logic                  w_fifo_nempty;
    logic                  w_avail;
    logic [TS_W-1:0]       w_head_ts;
    logic [DATA_WIDTH-1:0] w_hdr;

    assign w_push        = log_TVALID && r_ready;
    // The entry is retired once its header has been taken; the data word is
    // copied into the output register on that same edge.
    assign w_pop         = (r_state == S_HDR) && pk_TREADY;
    assign w_next_count  = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_fifo_nempty = (r_count != 2'd0);
    // A flit being pushed this cycle counts as available so an idle packer
    // can present its header on the very next cycle.
    assign w_avail       = w_fifo_nempty || w_push;

`ifdef LOG_PACK_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_ts [2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_ts;
        end
    end

    assign w_head_ts = w_fifo_nempty ? r_mem_ts[r_rd_ptr] : r_ts;
`else
    assign w_head_ts = '0;
`endif

    // Header of the head entry, or of the incoming flit when the FIFO is empty
    always_comb begin
        w_hdr = '0;
        if (w_fifo_nempty) begin
            w_hdr = {w_head_ts, r_mem_last[r_rd_ptr], r_mem_id[r_rd_ptr],
                     r_mem_dest[r_rd_ptr], r_mem_keep[r_rd_ptr]};
        end else begin
            w_hdr = {w_head_ts, log_TLAST, log_TID, log_TDEST, log_TKEEP};
        end
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= log_TDATA;
            r_mem_keep[r_wr_ptr] <= log_TKEEP;
            r_mem_dest[r_wr_ptr] <= log_TDEST;
            r_mem_id[r_wr_ptr]   <= log_TID;
            r_mem_last[r_wr_ptr] <= log_TLAST;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_next_count;
            // Registered ready: no combinational path from any input
            r_ready <= (w_next_count < 2'd2);
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: header flit, then data flit, back to back
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pk_data  <= '0;
            r_pk_valid <= 1'b0;
            r_pk_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_avail) begin
                        r_pk_data  <= w_hdr;
                        r_pk_valid <= 1'b1;
                        r_pk_last  <= 1'b0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (pk_TREADY) begin
                        r_pk_data <= r_mem_data[r_rd_ptr];
                        r_pk_last <= 1'b1;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (pk_TREADY) begin
                        if (w_avail) begin
                            r_pk_data  <= w_hdr;
                            r_pk_last  <= 1'b0;
                            r_state    <= S_HDR;
                        end else begin
                            r_pk_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_pk_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign log_TREADY = r_ready;
    assign pk_TDATA   = r_pk_data;
    assign pk_TVALID  = r_pk_valid;
    assign pk_TLAST   = r_pk_last;
    assign pk_TKEEP   = '1;

endmodule
`default_nettype wire

// File: tb/tb_axis_log_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_log_packer
//  Purpose  : Self-checking bench for axis_log_packer. Accepted input flits
//             are turned into expected header/data pairs in a queue and
//             compared as the packed stream hands them off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_log_packer;

    localparam int DW     = 64;
    localparam int DESTW  = 16;
    localparam int IDW    = 16;
    localparam int KW     = DW / 8;
    localparam int TSW    = DW - (KW + DESTW + IDW + 1);

    logic            clk = 1'b0;
    logic            rstn;
    logic [DW-1:0]   log_TDATA;
    logic            log_TVALID;
    logic            log_TREADY;
    logic [KW-1:0]   log_TKEEP;
    logic [DESTW-1:0] log_TDEST;
    logic [IDW-1:0]  log_TID;
    logic            log_TLAST;
    logic [DW-1:0]   pk_TDATA;
    logic            pk_TVALID;
    logic            pk_TREADY;
    logic [KW-1:0]   pk_TKEEP;
    logic            pk_TLAST;

    axis_log_packer #(
        .DATA_WIDTH (DW),
        .DEST_WIDTH (DESTW),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .log_TDATA  (log_TDATA),
        .log_TVALID (log_TVALID),
        .log_TREADY (log_TREADY),
        .log_TKEEP  (log_TKEEP),
        .log_TDEST  (log_TDEST),
        .log_TID    (log_TID),
        .log_TLAST  (log_TLAST),
        .pk_TDATA   (pk_TDATA),
        .pk_TVALID  (pk_TVALID),
        .pk_TREADY  (pk_TREADY),
        .pk_TKEEP   (pk_TKEEP),
        .pk_TLAST   (pk_TLAST)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference timestamp: cleared by reset, +1 on every edge afterwards
    logic [TSW-1:0] tb_ts;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    function automatic logic [TSW-1:0] exp_ts();
`ifdef LOG_PACK_TIMESTAMP_EN
        return tb_ts;
`else
        return '0;
`endif
    endfunction

    // Scoreboard entries are {tlast, tdata}
    logic [DW:0]     exp_q[$];
    logic            p_stall = 1'b0;
    logic [DW-1:0]   p_data  = '0;
    logic            p_last  = 1'b0;

    always @(negedge clk) begin
        if (rstn && log_TVALID && log_TREADY) begin
            exp_q.push_back({1'b0, exp_ts(), log_TLAST, log_TID, log_TDEST, log_TKEEP});
            exp_q.push_back({1'b1, log_TDATA});
        end
        if (rstn && p_stall) begin
            check("hold_valid", 64'(pk_TVALID), 64'd1);
            check("hold_data",  pk_TDATA, p_data);
            check("hold_last",  64'(pk_TLAST), 64'(p_last));
        end
        if (rstn && pk_TVALID && pk_TREADY) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("pk_data", pk_TDATA, e[DW-1:0]);
                check("pk_last", 64'(pk_TLAST), 64'(e[DW]));
                check("pk_keep", 64'(pk_TKEEP), 64'hFF);
            end
        end
        p_stall <= rstn && pk_TVALID && !pk_TREADY;
        p_data  <= pk_TDATA;
        p_last  <= pk_TLAST;
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send_flit(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [DESTW-1:0] de, input logic [IDW-1:0] id,
                             input logic la);
        bit done = 1'b0;
        int n = 0;
        log_TDATA  = d;
        log_TKEEP  = k;
        log_TDEST  = de;
        log_TID    = id;
        log_TLAST  = la;
        log_TVALID = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (log_TREADY) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("send_accepted", 64'(done), 64'd1);
        log_TVALID = 1'b0;
    endtask

    task automatic send_random();
        send_flit({$urandom, $urandom}, KW'($urandom), DESTW'($urandom),
                  IDW'($urandom), 1'($urandom));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        pk_TREADY = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    bit rand_rdy = 1'b0;
    logic [DW-1:0] c_hdr1;

    initial begin
        rstn       = 1'b0;
        log_TVALID = 1'b0;
        log_TDATA  = '0;
        log_TKEEP  = '0;
        log_TDEST  = '0;
        log_TID    = '0;
        log_TLAST  = 1'b0;
        pk_TREADY  = 1'b1;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(log_TREADY), 64'd0);
        check("rst_valid", 64'(pk_TVALID), 64'd0);
        check("rst_data",  pk_TDATA, 64'd0);
        check("rst_last",  64'(pk_TLAST), 64'd0);
        check("rst_keep",  64'(pk_TKEEP), 64'hFF);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rel_ready_0", 64'(log_TREADY), 64'd0);
        @(negedge clk);
        check("rel_ready_1", 64'(log_TREADY), 64'd1);
        check("rel_valid",   64'(pk_TVALID), 64'd0);

        // ---------------- single flit at counter = 5 ----------------
        for (int i = 0; i < 20 && tb_ts != TSW'(5); i++) begin
            @(posedge clk); #1;
        end
        check("ts_at_5", 64'(tb_ts), 64'd5);
        c_hdr1 = 64'h0000_0112_3400_A5FF;
`ifdef LOG_PACK_TIMESTAMP_EN
        c_hdr1 = c_hdr1 | (64'd5 << 41);
`endif
        log_TDATA  = 64'h1122334455667788;
        log_TKEEP  = 8'hFF;
        log_TDEST  = 16'h00A5;
        log_TID    = 16'h1234;
        log_TLAST  = 1'b1;
        log_TVALID = 1'b1;
        @(negedge clk);
        check("single_acc", 64'(log_TREADY), 64'd1);
        @(posedge clk); #1;
        log_TVALID = 1'b0;
        @(negedge clk);
        check("single_hdr_v", 64'(pk_TVALID), 64'd1);
        check("single_hdr",   pk_TDATA, c_hdr1);
        check("single_hdr_l", 64'(pk_TLAST), 64'd0);
        @(negedge clk);
        check("single_dat_v", 64'(pk_TVALID), 64'd1);
        check("single_dat",   pk_TDATA, 64'h1122334455667788);
        check("single_dat_l", 64'(pk_TLAST), 64'd1);
        @(negedge clk);
        check("single_idle",  64'(pk_TVALID), 64'd0);

        // ---------------- back-to-back with downstream stalled ----------------
        @(posedge clk); #1;
        pk_TREADY = 1'b0;
        send_flit(64'hA0A0_0000_0000_0001, 8'h0F, 16'h0001, 16'hAAAA, 1'b0);
        send_flit(64'hB0B0_0000_0000_0002, 8'hF0, 16'h0002, 16'hBBBB, 1'b1);
        @(negedge clk);
        check("full_ready", 64'(log_TREADY), 64'd0);
        repeat (4) @(negedge clk);
        check("full_ready_hold", 64'(log_TREADY), 64'd0);
        check("full_valid_hold", 64'(pk_TVALID), 64'd1);
        @(posedge clk); #1;
        pk_TREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_no_gap", 64'(pk_TVALID), 64'd1);
        end
        check("b2b_ready_back", 64'(log_TREADY), 64'd1);
        drain("b2b_drain");

        // ---------------- random traffic, random downstream ready ----------------
        rand_rdy = 1'b1;
        fork
            while (rand_rdy) begin
                @(posedge clk); #1;
                if (rand_rdy) pk_TREADY = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_random();
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        drain("rand_drain");

`ifdef LOG_PACK_TIMESTAMP_EN
        // ---------------- timestamp wrap ----------------
        dut.r_ts = {TSW{1'b1}};
        tb_ts    = {TSW{1'b1}};
        send_flit(64'h7777_0000_0000_0001, 8'hFF, 16'h0007, 16'h0007, 1'b0);
        send_flit(64'h0000_0000_0000_0002, 8'hFF, 16'h0008, 16'h0008, 1'b1);
        drain("wrap_drain");
`else
        send_flit(64'h7777_0000_0000_0001, 8'hFF, 16'h0007, 16'h0007, 1'b0);
        send_flit(64'h0000_0000_0000_0002, 8'hFF, 16'h0008, 16'h0008, 1'b1);
        drain("nots_drain");
`endif

        // ---------------- reset mid-record with full FIFO ----------------
        pk_TREADY = 1'b0;
        send_flit(64'hDEAD_0000_0000_0001, 8'h11, 16'h0101, 16'h1111, 1'b0);
        send_flit(64'hDEAD_0000_0000_0002, 8'h22, 16'h0202, 16'h2222, 1'b1);
        @(negedge clk);
        check("mid_full", 64'(log_TREADY), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pk_TVALID), 64'd0);
        check("mid_rst_ready", 64'(log_TREADY), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rstn      = 1'b1;
        pk_TREADY = 1'b1;
        send_flit(64'hC0FF_EE00_0000_0003, 8'h33, 16'h0303, 16'h3333, 1'b1);
        drain("mid_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a wait above goes astray
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
